// File: rtl/viterbi_rx_ctrl_if.sv
// Handshake and symbol-tagging bundle between the upstream word source,
// the Viterbi receive controller, the bit extractor and the ACS/traceback stages.
interface viterbi_rx_ctrl_if #(
    parameter int IDX_W = 5
) ();
    logic             i_valid;
    logic [15:0]      i_data;
    logic             o_ready;
    logic [15:0]      o_data;
    logic             o_en_ext;
    logic             i_acs_ready;
    logic             o_sym_valid;
    logic [IDX_W-1:0] o_sym_idx;
    logic             o_frame_last;
    logic             o_tb_start;
    logic             i_tb_done;
    logic             o_busy;

    // Environment side: supplies words, ACS back-pressure and traceback completion.
    modport master (
        output i_valid, i_data, i_acs_ready, i_tb_done,
        input  o_ready, o_data, o_en_ext, o_sym_valid, o_sym_idx,
        input  o_frame_last, o_tb_start, o_busy
    );

    // Controller side.
    modport slave (
        input  i_valid, i_data, i_acs_ready, i_tb_done,
        output o_ready, o_data, o_en_ext, o_sym_valid, o_sym_idx,
        output o_frame_last, o_tb_start, o_busy
    );
endinterface

// File: rtl/viterbi_rx_ctrl.sv
// Receive controller for the Viterbi front end: captures one 16-bit word at a
// time, steps the 2-bit MSB-first extractor through its 8 symbols under ACS
// back-pressure, tags each symbol with its trellis stage, and hands the frame
// to traceback after FRAME_WORDS words.
module viterbi_rx_ctrl #(
    parameter int SYMS_PER_WORD = 8,
    parameter int FRAME_WORDS   = 4,
    parameter int IDX_W         = 5
) (
    input  logic               clk,
    input  logic               rst,
    viterbi_rx_ctrl_if.slave   bus
);
    localparam int SYM_W  = $clog2(SYMS_PER_WORD);
    localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [SYM_W-1:0]  SYM_LAST   = SYM_W'(SYMS_PER_WORD - 1);
    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0]  STAGE_LAST = IDX_W'(SYMS_PER_WORD * FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_TB_WAIT = 2'd3
    } state_t;

    state_t            state_r;
    logic [SYM_W-1:0]  sym_cnt_r;
    logic [WORD_W-1:0] word_cnt_r;
    logic [IDX_W-1:0]  stage_cnt_r;
    logic [15:0]       data_r;
    logic              sym_valid_r;
    logic [IDX_W-1:0]  sym_idx_r;
    logic              frame_last_r;
    logic              tb_start_r;
    logic              en_ext_s;

    // Extractor enable: only in RUN, and only when the ACS can take the symbol.
    always_comb begin
        en_ext_s = 1'b0;
        if (state_r == ST_RUN) begin
            en_ext_s = bus.i_acs_ready;
        end else begin
            en_ext_s = 1'b0;
        end
    end

    // Frame sequencer plus the one-cycle-delayed symbol tags that line up with the extractor output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            sym_cnt_r    <= '0;
            word_cnt_r   <= '0;
            stage_cnt_r  <= '0;
            data_r       <= 16'h0000;
            sym_valid_r  <= 1'b0;
            sym_idx_r    <= '0;
            frame_last_r <= 1'b0;
            tb_start_r   <= 1'b0;
        end else begin
            sym_valid_r  <= en_ext_s;
            frame_last_r <= en_ext_s && (stage_cnt_r == STAGE_LAST);
            tb_start_r   <= 1'b0;
            if (en_ext_s) begin
                sym_idx_r <= stage_cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        data_r  <= bus.i_data;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en_ext_s) begin
                        stage_cnt_r <= stage_cnt_r + IDX_W'(1);
                        if (sym_cnt_r == SYM_LAST) begin
                            sym_cnt_r <= '0;
                            if (word_cnt_r == WORD_LAST) begin
                                state_r <= ST_FLUSH;
                            end else begin
                                word_cnt_r <= word_cnt_r + WORD_W'(1);
                                state_r    <= ST_IDLE;
                            end
                        end else begin
                            sym_cnt_r <= sym_cnt_r + SYM_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Last symbol is on the extractor output this cycle; kick traceback next.
                    tb_start_r <= 1'b1;
                    state_r    <= ST_TB_WAIT;
                end
                ST_TB_WAIT: begin
                    if (bus.i_tb_done) begin
                        word_cnt_r  <= '0;
                        stage_cnt_r <= '0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready      = (state_r == ST_IDLE);
    assign bus.o_busy       = (state_r != ST_IDLE);
    assign bus.o_en_ext     = en_ext_s;
    assign bus.o_data       = data_r;
    assign bus.o_sym_valid  = sym_valid_r;
    assign bus.o_sym_idx    = sym_idx_r;
    assign bus.o_frame_last = frame_last_r;
    assign bus.o_tb_start   = tb_start_r;
endmodule

// File: tb/tb_viterbi_rx_ctrl.sv
// Self-checking bench for viterbi_rx_ctrl: a behavioural extractor plus a
// per-word expected-symbol queue, and one task per scenario.
module tb_viterbi_rx_ctrl;
    localparam int IDX_W  = 5;
    localparam int SPW    = 8;
    localparam int FW     = 4;
    localparam int STAGES = SPW * FW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_rx_ctrl_if #(.IDX_W(IDX_W)) bus ();

    viterbi_rx_ctrl #(.SYMS_PER_WORD(SPW), .FRAME_WORDS(FW), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0, failures = 0;
    int sb_checks = 0, sb_fails = 0;

    // ACS back-pressure: either a forced level or a random one changing every cycle.
    logic acs_force = 1'b1;
    bit   rand_acs  = 1'b0;
    logic rnd_bit   = 1'b1;
    assign bus.i_acs_ready = rand_acs ? rnd_bit : acs_force;
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Extractor model: emits the next MSB-first 2-bit symbol one cycle after each enable.
    logic [2:0] ext_pos;
    logic [1:0] ext_rx;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pos <= 3'd0;
            ext_rx  <= 2'b00;
        end else if (bus.o_en_ext === 1'b1) begin
            ext_rx  <= bus.o_data[15 - 2 * int'(ext_pos) -: 2];
            ext_pos <= ext_pos + 3'd1;
        end else begin
            ext_rx  <= 2'b00;
        end
    end

    // Scoreboard: every accepted word queues its 8 expected (stage, symbol, last) tags.
    typedef struct { int idx; logic [1:0] sym; bit last; } exp_t;
    exp_t exp_q[$];
    exp_t e;
    int   fw_pos = 0;
    logic [15:0] acc_word;
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            fw_pos = 0;
        end else begin
            sb_checks++;
            if (bus.o_en_ext === 1'b1 && bus.i_acs_ready !== 1'b1) begin
                sb_fails++;
                $display("FAIL en_while_stalled got en=%b acs=%b t=%0t", bus.o_en_ext, bus.i_acs_ready, $time);
            end
            if (bus.o_sym_valid === 1'b1) begin
                sb_checks++;
                if (exp_q.size() == 0) begin
                    sb_fails++;
                    $display("FAIL unexpected_symbol got idx=%0d with empty queue t=%0t", bus.o_sym_idx, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.o_sym_idx !== IDX_W'(e.idx) || ext_rx !== e.sym || bus.o_frame_last !== e.last) begin
                        sb_fails++;
                        $display("FAIL symbol_tag got idx=%0d sym=%b last=%b expected idx=%0d sym=%b last=%b t=%0t",
                                 bus.o_sym_idx, ext_rx, bus.o_frame_last, e.idx, e.sym, e.last, $time);
                    end
                end
            end else begin
                sb_checks++;
                if (bus.o_frame_last !== 1'b0 || ext_rx !== 2'b00) begin
                    sb_fails++;
                    $display("FAIL idle_symbol got last=%b rx=%b expected 0/00 t=%0t", bus.o_frame_last, ext_rx, $time);
                end
            end
            if (bus.o_ready === 1'b1 && bus.i_valid === 1'b1) begin
                acc_word = bus.i_data;
                for (int k = 0; k < SPW; k++) begin
                    e.idx  = fw_pos * SPW + k;
                    e.sym  = acc_word[15 - 2 * k -: 2];
                    e.last = (e.idx == STAGES - 1);
                    exp_q.push_back(e);
                end
                fw_pos = (fw_pos + 1) % FW;
            end
        end
    end

    // Hands one word over once the controller is ready; called just after a rising edge.
    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout got ready=%b expected 1", bus.o_ready);
        end
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    // Counts extractor enables at falling edges, bounded.
    task automatic wait_enables(input int n, input string name);
        int cnt, cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.o_en_ext === 1'b1) cnt++;
        end
        checks++;
        if (cnt != n) begin
            failures++;
            $display("FAIL %s_enables got %0d expected %0d", name, cnt, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data = 16'h0000;
        bus.i_tb_done = 1'b0;
        acs_force = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_busy got %b%b expected 10", bus.o_ready, bus.o_busy);
        end
        checks++;
        if (bus.o_en_ext !== 1'b0) begin
            failures++;
            $display("FAIL reset_en got %b expected 0", bus.o_en_ext);
        end
        checks++;
        if (bus.o_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got %h expected 0000", bus.o_data);
        end
        checks++;
        if ({bus.o_sym_valid, bus.o_sym_idx, bus.o_frame_last, bus.o_tb_start} !== '0) begin
            failures++;
            $display("FAIL reset_tags got v=%b idx=%0d last=%b tb=%b expected all 0",
                     bus.o_sym_valid, bus.o_sym_idx, bus.o_frame_last, bus.o_tb_start);
        end
    endtask

    task automatic test_single_word();
        logic [1:0] exp_syms [8];
        exp_syms = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01};
        @(posedge clk); #1;
        send_word(16'hB4E1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_en_ext !== (c <= 8) || bus.o_sym_valid !== (c >= 2 && c <= 9) || bus.o_ready !== (c >= 9)) begin
                failures++;
                $display("FAIL single_timing c=%0d got en=%b v=%b rdy=%b expected %b%b%b", c,
                         bus.o_en_ext, bus.o_sym_valid, bus.o_ready, (c <= 8), (c >= 2 && c <= 9), (c >= 9));
            end
            if (c >= 2 && c <= 9) begin
                checks++;
                if (ext_rx !== exp_syms[c-2] || bus.o_sym_idx !== IDX_W'(c - 2)) begin
                    failures++;
                    $display("FAIL single_symbol c=%0d got sym=%b idx=%0d expected sym=%b idx=%0d",
                             c, ext_rx, bus.o_sym_idx, exp_syms[c-2], c - 2);
                end
            end
        end
        checks++;
        if (bus.o_data !== 16'hB4E1) begin
            failures++;
            $display("FAIL single_data got %h expected b4e1", bus.o_data);
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        send_word(16'($urandom));
        wait_enables(4, "stall_first");
        @(posedge clk); #1;
        acs_force = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_en_ext !== 1'b0 || bus.o_busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_pause c=%0d got en=%b busy=%b expected 0 1", c, bus.o_en_ext, bus.o_busy);
            end
        end
        @(posedge clk); #1;
        acs_force = 1'b1;
        wait_enables(4, "stall_rest");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore_valid();
        logic [15:0] w3, w4;
        w3 = 16'($urandom);
        w4 = 16'($urandom);
        @(posedge clk); #1;
        send_word(w3);
        bus.i_valid = 1'b1;
        bus.i_data  = ~w3;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_ready !== 1'b0 || bus.o_data !== w3) begin
                failures++;
                $display("FAIL run_no_capture c=%0d got rdy=%b data=%h expected 0 %h", c, bus.o_ready, bus.o_data, w3);
            end
        end
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        send_word(w4);
        wait_enables(8, "last_word");
        @(negedge clk);
        checks++;
        if (bus.o_tb_start !== 1'b0 || bus.o_frame_last !== 1'b1 || bus.o_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush got tb=%b last=%b busy=%b expected 0 1 1", bus.o_tb_start, bus.o_frame_last, bus.o_busy);
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b1;
        bus.i_data  = ~w4;
        @(negedge clk);
        checks++;
        if (bus.o_tb_start !== 1'b1 || bus.o_ready !== 1'b0) begin
            failures++;
            $display("FAIL tb_start_pulse got tb=%b rdy=%b expected 1 0", bus.o_tb_start, bus.o_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.o_tb_start !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_data !== w4) begin
                failures++;
                $display("FAIL tb_wait c=%0d got tb=%b rdy=%b data=%h expected 0 0 %h",
                         c, bus.o_tb_start, bus.o_ready, bus.o_data, w4);
            end
        end
        @(posedge clk); #1;
        bus.i_valid   = 1'b0;
        bus.i_tb_done = 1'b1;
        @(posedge clk); #1;
        bus.i_tb_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_data !== w4) begin
            failures++;
            $display("FAIL tb_done_idle got rdy=%b busy=%b data=%h expected 1 0 %h", bus.o_ready, bus.o_busy, bus.o_data, w4);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  seen, ready_leak;
        rand_acs = 1'b1;
        @(posedge clk); #1;
        for (int w = 0; w < FW; w++) begin
            send_word(16'($urandom));
        end
        cyc = 0;
        seen = 1'b0;
        ready_leak = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.o_ready !== 1'b0) ready_leak = 1'b1;
            if (bus.o_tb_start === 1'b1) begin
                seen = 1'b1;
                bus.i_tb_done = 1'b1;
            end
        end
        checks++;
        if (!seen || ready_leak) begin
            failures++;
            $display("FAIL b2b_tb_start got seen=%b ready_leak=%b expected 1 0", seen, ready_leak);
        end
        @(posedge clk); #1;
        bus.i_tb_done = 1'b0;
        rand_acs = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_tb_start !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_done got rdy=%b tb=%b pending=%0d expected 1 0 0", bus.o_ready, bus.o_tb_start, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] wc;
        @(posedge clk); #1;
        send_word(16'($urandom));
        wait_enables(8, "mid_w1");
        @(posedge clk); #1;
        send_word(16'($urandom));
        wait_enables(3, "mid_w2");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_data !== 16'h0000 ||
            {bus.o_sym_valid, bus.o_sym_idx, bus.o_frame_last, bus.o_tb_start} !== '0) begin
            failures++;
            $display("FAIL mid_reset got rdy=%b busy=%b data=%h v=%b idx=%0d expected 1 0 0000 0 0",
                     bus.o_ready, bus.o_busy, bus.o_data, bus.o_sym_valid, bus.o_sym_idx);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wc = 16'($urandom);
        send_word(wc);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (bus.o_sym_idx !== '0 || ext_rx !== wc[15:14] || bus.o_sym_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL post_reset_first got idx=%0d sym=%b v=%b expected 0 %b 1",
                             bus.o_sym_idx, ext_rx, bus.o_sym_valid, wc[15:14]);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_drain got pending=%0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_stall();
        test_ignore_valid();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge clk);
        checks   = checks + sb_checks;
        failures = failures + sb_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/viterbi_rx_ctrl.md
Name: viterbi_rx_ctrl

Overview:
- Sequences the 16-bit received-word bit extractor at the front of the Viterbi decoder.
- Accepts received words from upstream with a valid/ready handshake and holds each word stable for the extractor.
- Issues exactly 8 extract enables per word, pausing while the ACS stage is not ready.
- Tags each 2-bit symbol with its trellis stage index; after FRAME_WORDS words, starts traceback and waits for it to finish.

Parameters:
- SYMS_PER_WORD, 8, 2-bit symbols per 16-bit word; fixed at 8 to match the extractor's MSB-first, 2-bit step.
- FRAME_WORDS, 4, words per decode frame; 32 trellis stages at default.
- IDX_W, 5, width of the stage index; must satisfy 2^IDX_W >= SYMS_PER_WORD*FRAME_WORDS.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-low reset; the extractor shares it.
- i_valid, input, 1, upstream word valid.
- i_data, input, 16, upstream received word.
- o_ready, output, 1, controller can accept a word this cycle.
- o_data, output, 16, registered word driven to the extractor's i_data.
- o_en_ext, output, 1, extractor enable.
- i_acs_ready, input, 1, ACS stage can take a symbol next cycle.
- o_sym_valid, output, 1, extractor o_rx holds a valid symbol this cycle.
- o_sym_idx, output, IDX_W, trellis stage index of the current symbol.
- o_frame_last, output, 1, current symbol is the final stage of the frame.
- o_tb_start, output, 1, one-cycle traceback start pulse.
- i_tb_done, input, 1, traceback finished.
- o_busy, output, 1, high in any state other than IDLE.

Behaviour:
- States: IDLE, RUN, FLUSH, TB_WAIT. Counters: sym_cnt (0..7), word_cnt (0..FRAME_WORDS-1), stage_cnt (IDX_W bits).
- Reset (async, rst=0):
  - State goes to IDLE.
  - o_data=0, o_sym_valid=0, o_sym_idx=0, o_frame_last=0, o_tb_start=0.
  - All counters cleared.
  - Reset mid-frame discards the partial frame; the extractor realigns because it shares rst.
- IDLE:
  - o_ready=1, o_en_ext=0.
  - On i_valid=1: capture i_data into o_data, then go to RUN next cycle.
  - o_data is held unchanged outside this capture.
- RUN:
  - o_ready=0.
  - o_en_ext = i_acs_ready (combinational, gated by state==RUN).
  - Each enabled cycle increments sym_cnt and stage_cnt.
  - With i_acs_ready=0: o_en_ext=0 and counters hold. The extractor's internal position holds too, so pauses of any length are safe.
  - Enabled cycle with sym_cnt=7: sym_cnt wraps to 0.
    - If word_cnt<FRAME_WORDS-1: word_cnt+1, go to IDLE.
    - Otherwise: go to FLUSH.
- Symbol tagging:
  - o_sym_valid is o_en_ext registered one cycle, matching the extractor's one-cycle o_rx latency.
  - o_sym_idx is stage_cnt registered alongside it.
  - o_frame_last=1 together with o_sym_valid for stage SYMS_PER_WORD*FRAME_WORDS-1 (31 at default).
- FLUSH:
  - Lasts one cycle, during which the last symbol's o_sym_valid is high.
  - Next cycle: enter TB_WAIT with o_tb_start=1 for exactly that first cycle.
- TB_WAIT:
  - o_ready=0.
  - On i_tb_done=1: clear word_cnt and stage_cnt, go to IDLE.
  - i_tb_done is ignored in every other state.
  - i_tb_done asserted in the same cycle as o_tb_start is accepted.
- Throughput: minimum 9 cycles per word (1 capture + 8 enables). No back-to-back overlap: o_ready stays low until the word's 8th enable has issued.
- The controller never asserts o_en_ext outside RUN, so extractor output is 00 whenever o_sym_valid=0.
- stage_cnt never wraps within a frame; the IDX_W constraint guarantees this.

Test Plan:
- Reset, then hold i_valid=0 -> o_ready=1, o_busy=0, o_en_ext=0, all outputs 0.
- One word 0xB4E1, i_acs_ready=1 -> o_en_ext high for cycles 1..8 after capture; o_sym_valid high for cycles 2..9; o_sym_idx 0..7; extractor symbols 10,11,01,00,11,10,00,01.
- Drop i_acs_ready for 3 cycles after the 4th enable -> o_en_ext low for those 3 cycles; symbol 4 (idx 4) follows with no skipped or repeated symbol.
- Send 4 words back to back -> o_sym_idx runs 0..31; o_frame_last only at idx 31; o_tb_start pulses once, 2 cycles after the last enable; o_ready stays 0 until i_tb_done.
- Assert i_valid during RUN and TB_WAIT -> no capture, and o_data stays unchanged.
- Pulse rst low during word 2 of a frame -> immediate return to the reset values; the next frame starts at o_sym_idx=0 with correct MSB-first symbols.
